// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single CPU memory port: CPU (R0) and loader/debug (R1).
// Round-robin by default; define MEM_ARB_CPU_PRIO_EN to give the CPU fixed priority on ties.
module mem_port_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          R0_REQ,
    input  logic          R0_WE,
    input  logic [AW-1:0] R0_ADDR,
    input  logic [DW-1:0] R0_WDATA,
    output logic          R0_ACK,
    input  logic          R1_REQ,
    input  logic          R1_WE,
    input  logic [AW-1:0] R1_ADDR,
    input  logic [DW-1:0] R1_WDATA,
    output logic          R1_ACK,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    GRANT,
    output logic          BUSY,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          pick_r1;

    always_comb begin
        pick_r1 = 1'b0;
`ifdef MEM_ARB_CPU_PRIO_EN
        pick_r1 = R1_REQ && !R0_REQ;
`else
        // On a tie the requester not served last wins.
        pick_r1 = R1_REQ && (!R0_REQ || !last);
`endif
    end

    // MEM_WE/MEM_ADDR/MEM_WDATA double as the latched request registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            GRANT     <= '0;
            BUSY      <= 1'b0;
            R0_ACK    <= 1'b0;
            R1_ACK    <= 1'b0;
            RDATA     <= '0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else begin
            R0_ACK <= 1'b0;
            R1_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (R0_REQ || R1_REQ) begin
                        state     <= ACCESS;
                        cnt       <= CW'(MEM_LAT - 1);
                        BUSY      <= 1'b1;
                        MEM_EN    <= 1'b1;
                        GRANT     <= pick_r1 ? 2'b10 : 2'b01;
                        MEM_WE    <= pick_r1 ? R1_WE : R0_WE;
                        MEM_ADDR  <= pick_r1 ? R1_ADDR : R0_ADDR;
                        MEM_WDATA <= pick_r1 ? R1_WDATA : R0_WDATA;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!MEM_WE) begin
                            RDATA <= MEM_RDATA;
                        end
                        state  <= DONE;
                        MEM_EN <= 1'b0;
                        MEM_WE <= 1'b0;
                        R0_ACK <= GRANT[0];
                        R1_ACK <= GRANT[1];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    last  <= GRANT[1];
                    GRANT <= '0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks, a negedge monitor pops them.
// A second instance with MEM_LAT=1 checks back-to-back throughput of a held request.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [15:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
    logic        r0_ack, r1_ack, busy, mem_en, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant;

    logic        rst1 = 1'b1;
    logic        u1_req = 1'b0;
    logic        u1_ack, u1_r1_ack, u1_busy, u1_mem_en, u1_mem_we;
    logic [15:0] u1_rdata, u1_mem_addr, u1_mem_wdata;
    logic [1:0]  u1_grant;

    logic [15:0] mem [0:255];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          u1_acks = 0;
    int          u1_last = -1;
    logic        prev_ack = 1'b0;

    typedef struct {
        int          id;
        logic [15:0] rdata;
        int          ack_edge;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) dut (
        .CLK(clk), .RESET(rst),
        .R0_REQ(r0_req), .R0_WE(r0_we), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata), .R0_ACK(r0_ack),
        .R1_REQ(r1_req), .R1_WE(r1_we), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata), .R1_ACK(r1_ack),
        .RDATA(rdata), .GRANT(grant), .BUSY(busy),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut_lat1 (
        .CLK(clk), .RESET(rst1),
        .R0_REQ(u1_req), .R0_WE(1'b0), .R0_ADDR(16'h0007), .R0_WDATA(16'h0000), .R0_ACK(u1_ack),
        .R1_REQ(1'b0), .R1_WE(1'b0), .R1_ADDR(16'h0000), .R1_WDATA(16'h0000), .R1_ACK(u1_r1_ack),
        .RDATA(u1_rdata), .GRANT(u1_grant), .BUSY(u1_busy),
        .MEM_EN(u1_mem_en), .MEM_WE(u1_mem_we), .MEM_ADDR(u1_mem_addr), .MEM_WDATA(u1_mem_wdata),
        .MEM_RDATA(16'h5A5A)
    );

    assign mem_rdata = mem_en ? mem[mem_addr[7:0]] : 16'h0000;
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic req, input logic we,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (id == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Single request from idle; corrupt=1 drops REQ and scrambles ADDR/WE/WDATA in the first ACCESS cycle.
    task automatic do_req(input int id, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd, input bit corrupt);
        int   issue;
        exp_t e;
        tick();
        drive(id, 1'b1, we, addr, wdata);
        issue = cyc + 1;
        e.id = id; e.rdata = exp_rd; e.ack_edge = issue + LAT + 1;
        exp_q.push_back(e);
        tick();
        if (corrupt) drive(id, 1'b0, ~we, 16'hFFFF, ~wdata);
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            check("access_en", mem_en, 1'b1);
            check("access_addr", mem_addr, addr);
            check("access_we", mem_we, we);
            if (we) check("access_wdata", mem_wdata, wdata);
        end
        @(negedge clk);
        check("done_en", {mem_en, mem_we}, 2'b00);
        check("done_busy", busy, 1'b1);
        while (cyc < issue + LAT + 1) tick();
        drive(id, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
    endtask

    // Both requesters held high through n grants.
    task automatic do_tie(input int n);
        int   g;
        exp_t e;
`ifdef MEM_ARB_CPU_PRIO_EN
        int order[4] = '{0, 0, 0, 0};
`else
        int order[4] = '{0, 1, 0, 1};
`endif
        tick();
        drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        g = cyc + 1;
        for (int i = 0; i < n; i++) begin
            e.id = order[i];
            e.rdata = (order[i] == 0) ? 16'h1010 : 16'h2020;
            e.ack_edge = g + i * (LAT + 2) + LAT + 1;
            exp_q.push_back(e);
        end
        while (cyc < g + (n - 1) * (LAT + 2) + LAT + 1) tick();
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) check("grant_onehot", (grant == 2'b01) || (grant == 2'b10), 1'b1);
        if (r0_ack || r1_ack) begin
            check("ack_overlap", r0_ack && r1_ack, 1'b0);
            check("ack_single_pulse", prev_ack, 1'b0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got r0=%b r1=%b expected none (cycle %0d)", r0_ack, r1_ack, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ack_id", r1_ack ? 32'd1 : 32'd0, e.id);
                check("ack_rdata", rdata, e.rdata);
                check("ack_latency", cyc + 1, e.ack_edge);
                check("ack_grant", grant, (e.id == 1) ? 2'b10 : 2'b01);
            end
        end
        prev_ack = r0_ack || r1_ack;
    end

    always @(negedge clk) begin
        if (!rst1 && u1_ack) begin
            if (u1_last >= 0) check("lat1_spacing", cyc - u1_last, 3);
            check("lat1_rdata", u1_rdata, 16'h5A5A);
            check("lat1_r1_ack", u1_r1_ack, 1'b0);
            u1_last = cyc;
            u1_acks++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h40] = 16'hBEEF;
        mem[8'h41] = 16'hCAFE;
        mem[8'h10] = 16'h1010;
        mem[8'h20] = 16'h2020;

        tick();
        tick();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {r0_ack, r1_ack}, 2'b00);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_rdata", rdata, 16'h0000);
        rst = 1'b0;
        rst1 = 1'b0;
        u1_req = 1'b1;

        do_req(0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b0);
        do_req(1, 1'b1, 16'h1234, 16'h00FF, 16'hBEEF, 1'b0);
        do_req(1, 1'b0, 16'h1234, 16'h0000, 16'h00FF, 1'b0);
        do_req(0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1);

        reset_pulse();
        do_tie(4);

        // Reset lands in the second ACCESS cycle: access dropped, no ack.
        tick();
        drive(0, 1'b1, 1'b0, 16'h0041, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        @(negedge clk);
        check("midrst_mem_en", mem_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_grant", grant, 2'b00);
        rst = 1'b0;
        do_tie(1);

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        check("lat1_acks_seen", u1_acks > 5, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single 16-bit memory port between two requesters: requester 0 is the CPU datapath (fetch, data and stack accesses); requester 1 is the external loader/debug port.
- Serialises one access at a time through a small state machine, holds the memory control lines for a parameterised latency, and returns read data with a one-cycle ack pulse.
- Sits between the CPU top level and the memory block. The CPU control unit stalls on R0_ACK.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 2, memory cycles per access. Legal range 1..15; 0 is illegal.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- R0_REQ  in  1  CPU request; held high until R0_ACK.
- R0_WE  in  1  CPU write enable: 1 = write, 0 = read.
- R0_ADDR  in  AW  CPU address.
- R0_WDATA  in  DW  CPU write data.
- R0_ACK  out  1  one-cycle completion pulse to CPU.
- R1_REQ, R1_WE, R1_ADDR, R1_WDATA, R1_ACK: same as the R0 set, for the loader.
- RDATA  out  DW  read data, valid in the ack cycle, shared by both requesters.
- GRANT  out  2  one-hot owner of the current access: bit0 = CPU, bit1 = loader.
- BUSY  out  1  high whenever the state is not IDLE.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data; valid in the last MEM_EN cycle.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high.
- Values after reset: state = IDLE, GRANT = 0, BUSY = 0, all ACKs = 0, MEM_EN = 0, MEM_WE = 0, MEM_ADDR = 0, MEM_WDATA = 0, RDATA = 0, LAST = 1 (loader last served).
- State IDLE:
  - If any REQ is high, choose a winner.
  - Latch the winner's WE, ADDR and WDATA into internal registers.
  - Set GRANT, load CNT = MEM_LAT-1, go to ACCESS.
  - No requests: stay in IDLE.
- State ACCESS:
  - MEM_EN = 1. MEM_WE, MEM_ADDR and MEM_WDATA are driven from the latched registers.
  - These values are held stable for exactly MEM_LAT cycles.
  - CNT decrements each cycle. When CNT = 0:
    - On a read, capture MEM_RDATA into RDATA.
    - Go to DONE.
- State DONE:
  - MEM_EN = 0 and MEM_WE = 0.
  - ACK of the granted requester = 1 for exactly one cycle. RDATA is valid in this cycle.
  - Update LAST to the granted requester, clear GRANT, go to IDLE.
- Latency: a REQ sampled in IDLE produces its ACK MEM_LAT+1 cycles later. The minimum cycle spacing between consecutive grants is MEM_LAT+2.
- Arbitration: round-robin. When both requesters are high in IDLE, the one not equal to LAST wins. A single requester always wins.
- Writes leave RDATA unchanged.
- A requester that keeps REQ high in the cycle after its ACK is treated as a new request and re-arbitrated in IDLE.
- A request is committed once latched. Dropping REQ or changing ADDR, WE or WDATA during ACCESS has no effect; the access completes and is acked.
- Only one ACK is ever high at a time. ACK is never asserted to a requester that was not granted.
- RESET mid-operation: next edge returns to IDLE with MEM_EN = 0. The in-flight access is dropped and no ACK is issued. LAST resets to 1.
- BUSY = 1 in ACCESS and DONE.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. R0 (CPU) always wins a tie in IDLE. LAST is still updated but is ignored.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- CPU read alone, MEM_LAT=2: R0_REQ=1, R0_WE=0, R0_ADDR=0x0040, memory returns 0xBEEF -> MEM_EN high for 2 cycles with MEM_ADDR=0x0040; R0_ACK pulses 3 cycles after the REQ sample edge with RDATA=0xBEEF; R1_ACK stays 0.
- Loader write: R1_REQ=1, R1_WE=1, R1_ADDR=0x1234, R1_WDATA=0x00FF -> MEM_WE=1 and MEM_WDATA=0x00FF for 2 cycles, then one R1_ACK pulse; RDATA unchanged from its previous value.
- Tie after reset, both REQs held high through 4 grants -> grant order CPU, loader, CPU, loader; GRANT stays one-hot; ACKs never overlap. With MEM_ARB_CPU_PRIO_EN defined -> CPU, CPU, CPU, CPU.
- REQ dropped and ADDR changed to 0xFFFF in the first ACCESS cycle -> MEM_ADDR keeps the latched 0x0040 and the ACK is still issued.
- RESET asserted in the second ACCESS cycle -> next edge gives MEM_EN=0, BUSY=0, no ACK; a new tie after reset goes to the CPU.
- MEM_LAT=1, R0_REQ held high continuously -> R0_ACK pulses every 3 cycles, one access per grant.
